// File: rtl/rj_pkg.sv
// Shared types and width helpers for the ring/Johnson code decoder.
package rj_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } rj_state_t;

    function automatic int rj_ring_idx_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic int rj_john_idx_w(input int width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/rj_seq_tracker.sv
// Lock/continuity tracker for one decoded code channel with a wrapping index.
module rj_seq_tracker
    import rj_pkg::*;
#(
    parameter int MODULUS = 4,
    parameter int IDX_W   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             legal_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             locked_o,
    output logic             code_err_o,
    output logic             seq_err_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             err_next_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MODULUS - 1);

    rj_state_t        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, next_exp_s;
    logic             code_err_q, code_err_d;
    logic             seq_err_q, seq_err_d;

    assign next_exp_s = (idx_q == LAST_IDX) ? IDX_W'(0) : idx_q + IDX_W'(1);

    // Next state: illegal codes hold the index, legal ones always reload it.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        code_err_d = 1'b0;
        seq_err_d  = 1'b0;
        if (en_i) begin
            case (state_q)
                UNLOCKED: begin
                    if (legal_i) begin
                        state_d = LOCKED;
                        idx_d   = idx_i;
                    end else begin
                        code_err_d = 1'b1;
                    end
                end
                LOCKED: begin
                    if (legal_i) begin
                        idx_d     = idx_i;
                        seq_err_d = (idx_i != next_exp_s);
                    end else begin
                        state_d    = UNLOCKED;
                        code_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = UNLOCKED;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State, held index and one-cycle error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= UNLOCKED;
            idx_q      <= '0;
            code_err_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            code_err_q <= code_err_d;
            seq_err_q  <= seq_err_d;
        end
    end

    assign locked_o   = (state_q == LOCKED);
    assign code_err_o = code_err_q;
    assign seq_err_o  = seq_err_q;
    assign idx_o      = idx_q;
    assign err_next_o = code_err_d | seq_err_d;

endmodule

// File: rtl/ring_johnson_decoder.sv
// Decodes ring and Johnson codes, tracks sequence lock, counts errors.
// Define RJ_DEC_ERR_CNT_EN to build the saturating err_cnt register.
module ring_johnson_decoder
    import rj_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic [WIDTH-1:0]                  ring_in,
    input  logic [WIDTH-1:0]                  john_in,
    output logic [rj_ring_idx_w(WIDTH)-1:0]   ring_idx,
    output logic [rj_john_idx_w(WIDTH)-1:0]   john_idx,
    output logic                              ring_locked,
    output logic                              john_locked,
    output logic                              ring_code_err,
    output logic                              john_code_err,
    output logic                              ring_seq_err,
    output logic                              john_seq_err,
    output logic [ERR_CNT_W-1:0]              err_cnt
);

    localparam int RIDX_W = rj_ring_idx_w(WIDTH);
    localparam int JIDX_W = rj_john_idx_w(WIDTH);
    localparam logic [JIDX_W:0]   TWO_W = (JIDX_W + 1)'(2 * WIDTH);
    localparam logic [WIDTH-1:0]  ONE_W = WIDTH'(1);

    logic [JIDX_W-1:0] ring_cnt_s, john_cnt_s, john_idx_s;
    logic [RIDX_W-1:0] ring_pos_s;
    logic [JIDX_W:0]   john_alt_s;
    logic [WIDTH-1:0]  john_inv_s;
    logic              ring_legal_s, john_legal_s;
    logic              ring_evt_s, john_evt_s;

    // Ring decode: one-hot check and set-bit position.
    always_comb begin
        ring_cnt_s = '0;
        ring_pos_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ring_cnt_s = ring_cnt_s + JIDX_W'(ring_in[i]);
            ring_pos_s = ring_pos_s | (ring_in[i] ? RIDX_W'(i) : RIDX_W'(0));
        end
        ring_legal_s = (ring_cnt_s == JIDX_W'(1));
    end

    // Johnson decode: x & (x+1) == 0 detects a run of ones anchored at the LSB;
    // applying it to ~x detects a run anchored at the MSB.
    always_comb begin
        john_cnt_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            john_cnt_s = john_cnt_s + JIDX_W'(john_in[i]);
        end
        john_inv_s   = ~john_in;
        john_legal_s = ((john_in & (john_in + ONE_W)) == '0) ||
                       ((john_inv_s & (john_inv_s + ONE_W)) == '0);
        john_alt_s   = TWO_W - {1'b0, john_cnt_s};
        if (john_in[WIDTH-1] || (john_in == '0)) begin
            john_idx_s = john_cnt_s;
        end else begin
            john_idx_s = john_alt_s[JIDX_W-1:0];
        end
    end

    rj_seq_tracker #(
        .MODULUS (WIDTH),
        .IDX_W   (RIDX_W)
    ) u_ring_trk (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (en),
        .legal_i    (ring_legal_s),
        .idx_i      (ring_pos_s),
        .locked_o   (ring_locked),
        .code_err_o (ring_code_err),
        .seq_err_o  (ring_seq_err),
        .idx_o      (ring_idx),
        .err_next_o (ring_evt_s)
    );

    rj_seq_tracker #(
        .MODULUS (2 * WIDTH),
        .IDX_W   (JIDX_W)
    ) u_john_trk (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (en),
        .legal_i    (john_legal_s),
        .idx_i      (john_idx_s),
        .locked_o   (john_locked),
        .code_err_o (john_code_err),
        .seq_err_o  (john_seq_err),
        .idx_o      (john_idx),
        .err_next_o (john_evt_s)
    );

`ifdef RJ_DEC_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [ERR_CNT_W:0]   err_sum_s;

    // Saturating add of this cycle's error events (0..2).
    always_comb begin
        err_sum_s = {1'b0, err_cnt_q} + {{ERR_CNT_W{1'b0}}, ring_evt_s}
                                      + {{ERR_CNT_W{1'b0}}, john_evt_s};
        if (err_sum_s[ERR_CNT_W]) begin
            err_cnt_d = '1;
        end else begin
            err_cnt_d = err_sum_s[ERR_CNT_W-1:0];
        end
    end

    // Error counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_evt_s;
    assign unused_evt_s = ring_evt_s | john_evt_s;
    assign err_cnt      = {ERR_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_ring_johnson_decoder.sv
// Directed self-checking bench for ring_johnson_decoder (WIDTH=4, ERR_CNT_W=8).
module tb_ring_johnson_decoder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] ring_in;
    logic [3:0] john_in;
    logic [1:0] ring_idx;
    logic [2:0] john_idx;
    logic       ring_locked, john_locked;
    logic       ring_code_err, john_code_err;
    logic       ring_seq_err, john_seq_err;
    logic [7:0] err_cnt;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    logic [3:0] john_tab [8];
    logic [3:0] ring_v;

    ring_johnson_decoder #(
        .WIDTH     (4),
        .ERR_CNT_W (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .ring_in       (ring_in),
        .john_in       (john_in),
        .ring_idx      (ring_idx),
        .john_idx      (john_idx),
        .ring_locked   (ring_locked),
        .john_locked   (john_locked),
        .ring_code_err (ring_code_err),
        .john_code_err (john_code_err),
        .ring_seq_err  (ring_seq_err),
        .john_seq_err  (john_seq_err),
        .err_cnt       (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Error-count model: adds pulses only when the counter is built.
    task automatic bump(input int n);
`ifdef RJ_DEC_ERR_CNT_EN
        exp_cnt = (exp_cnt + n > 255) ? 255 : exp_cnt + n;
`else
        exp_cnt = exp_cnt + 0 * n;
`endif
    endtask

    task automatic step(input logic e, input logic [3:0] r, input logic [3:0] j);
        en      = e;
        ring_in = r;
        john_in = j;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag,
                              input logic [31:0] ri, input logic [31:0] ji,
                              input logic rl, input logic jl,
                              input logic rce, input logic jce,
                              input logic rse, input logic jse);
        chk({tag, ".ring_idx"},      32'(ring_idx),      ri);
        chk({tag, ".john_idx"},      32'(john_idx),      ji);
        chk({tag, ".ring_locked"},   32'(ring_locked),   32'(rl));
        chk({tag, ".john_locked"},   32'(john_locked),   32'(jl));
        chk({tag, ".ring_code_err"}, 32'(ring_code_err), 32'(rce));
        chk({tag, ".john_code_err"}, 32'(john_code_err), 32'(jce));
        chk({tag, ".ring_seq_err"},  32'(ring_seq_err),  32'(rse));
        chk({tag, ".john_seq_err"},  32'(john_seq_err),  32'(jse));
        chk({tag, ".err_cnt"},       32'(err_cnt),       32'(exp_cnt));
    endtask

    initial begin
        john_tab = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                     4'b1111, 4'b0111, 4'b0011, 4'b0001};
        rst_n   = 1'b0;
        en      = 1'b0;
        ring_in = 4'b0000;
        john_in = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        rst_n = 1'b1;
        step(1'b0, 4'b0110, 4'b1010);
        step(1'b0, 4'b0110, 4'b1010);
        expect_out("en0_after_release", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Both channels walk their full legal sequence together.
        for (int k = 0; k < 9; k++) begin
            ring_v = 4'b0001 << (k % 4);
            step(1'b1, ring_v, john_tab[k % 8]);
            expect_out($sformatf("walk%0d", k), 32'(k % 4), 32'(k % 8),
                       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        step(1'b1, 4'b0100, 4'b1000);
        bump(1);
        expect_out("ring_skip", 32'd2, 32'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        step(1'b1, 4'b1000, 4'b1100);
        expect_out("ring_resync", 32'd3, 32'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        step(1'b1, 4'b0110, 4'b1010);
        bump(2);
        expect_out("dual_illegal", 32'd3, 32'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            step(1'b1, 4'b0110, 4'b1010);
            bump(2);
            if (i == 0) begin
                expect_out("back_to_back", 32'd3, 32'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            end
        end
        expect_out("burst_end", 32'd3, 32'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef RJ_DEC_ERR_CNT_EN
        chk("err_cnt_saturated", 32'(err_cnt), 32'd255);
`else
        chk("err_cnt_disabled", 32'(err_cnt), 32'd0);
`endif

        step(1'b1, 4'b0100, 4'b1110);
        expect_out("relock", 32'd2, 32'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        step(1'b1, 4'b0110, 4'b1010);
        bump(2);
        expect_out("pre_reset_err", 32'd2, 32'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Reset lands between clock edges and must act immediately.
        step(1'b1, 4'b0100, 4'b1110);
        expect_out("pre_reset_lock", 32'd2, 32'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        expect_out("async_reset", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        step(1'b0, 4'b0000, 4'b0000);
        rst_n = 1'b1;
        step(1'b1, 4'b0010, 4'b0111);
        expect_out("first_after_reset", 32'd1, 32'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        step(1'b0, 4'b0110, 4'b1010);
        expect_out("en0_hold", 32'd1, 32'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        step(1'b1, 4'b0100, 4'b0011);
        expect_out("resume", 32'd2, 32'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
